// File: rtl/udp_echo_responder.sv
// UDP echo responder: swaps addresses/ports of datagrams sent to LOCAL_PORT and
// re-emits the payload one byte per cycle. Optional drop counter: UDP_ECHO_DROP_CNT_EN.
module udp_echo_responder #(
  parameter logic [15:0] LOCAL_PORT = 16'd1234,
  parameter logic [7:0]  ECHO_TTL   = 8'd64
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        s_udp_hdr_valid,
  output logic        s_udp_hdr_ready,
  input  logic [31:0] s_udp_ip_source_ip,
  input  logic [31:0] s_udp_ip_dest_ip,
  input  logic [15:0] s_udp_source_port,
  input  logic [15:0] s_udp_dest_port,
  input  logic [15:0] s_udp_length,

  input  logic [63:0] s_udp_payload_axis_tdata,
  input  logic [7:0]  s_udp_payload_axis_tkeep,
  input  logic        s_udp_payload_axis_tvalid,
  output logic        s_udp_payload_axis_tready,
  input  logic        s_udp_payload_axis_tlast,
  input  logic        s_udp_payload_axis_tuser,

  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_source_ip,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,

  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic [7:0]  m_udp_payload_axis_tkeep,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser
`ifdef UDP_ECHO_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DROP    = 2'd1;
  localparam logic [1:0] ST_HDR     = 2'd2;
  localparam logic [1:0] ST_PAYLOAD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        hdr_ready_q, hdr_ready_d;
  logic [31:0] src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [15:0] src_port_q, src_port_d, dst_port_q, dst_port_d;
  logic [15:0] length_q, length_d;
  logic [7:0]  ttl_q, ttl_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  keep_q, keep_d;
  logic        last_q, last_d, user_q, user_d, in_done_q, in_done_d;

  logic hdr_hs_s, out_valid_s, out_hs_s, final_byte_s, frame_end_s;
  logic pl_ready_s, s_ready_s, pl_in_hs_s, drop_end_s;

  // Handshake decode; the holding register drains lane 0 first, so keep_q[0]
  // marks a pending byte and a clear keep_q[1] marks the beat's final byte.
  always_comb begin
    hdr_hs_s     = s_udp_hdr_valid && hdr_ready_q;
    out_valid_s  = keep_q[0];
    out_hs_s     = out_valid_s && m_udp_payload_axis_tready;
    final_byte_s = !keep_q[1];
    frame_end_s  = out_hs_s && final_byte_s && last_q;
    pl_ready_s   = (state_q == ST_PAYLOAD) && !in_done_q &&
                   (!out_valid_s || (out_hs_s && final_byte_s));
    s_ready_s    = pl_ready_s || (state_q == ST_DROP);
    pl_in_hs_s   = pl_ready_s && s_udp_payload_axis_tvalid;
    drop_end_s   = (state_q == ST_DROP) && s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast;
  end

  // Next-state logic for the FSM and the swapped reply header
  always_comb begin
    state_d    = state_q;
    src_ip_d   = src_ip_q;
    dst_ip_d   = dst_ip_q;
    src_port_d = src_port_q;
    dst_port_d = dst_port_q;
    length_d   = length_q;
    ttl_d      = ttl_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_hs_s && (s_udp_dest_port == LOCAL_PORT)) begin
          state_d    = ST_HDR;
          src_ip_d   = s_udp_ip_dest_ip;
          dst_ip_d   = s_udp_ip_source_ip;
          src_port_d = s_udp_dest_port;
          dst_port_d = s_udp_source_port;
          length_d   = s_udp_length;
          ttl_d      = ECHO_TTL;
        end else if (hdr_hs_s) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (drop_end_s) state_d = ST_IDLE;
        else            state_d = ST_DROP;
      end
      ST_HDR: begin
        if (m_udp_hdr_ready) state_d = ST_PAYLOAD;
        else                 state_d = ST_HDR;
      end
      ST_PAYLOAD: begin
        if (frame_end_s) state_d = ST_IDLE;
        else             state_d = ST_PAYLOAD;
      end
      default: state_d = ST_IDLE;
    endcase
    hdr_ready_d = (state_d == ST_IDLE);
  end

  // Holding register: shift out one byte per handshake, reload on an accepted beat.
  // An empty tlast beat becomes a single 8'h00 byte so the frame still terminates.
  always_comb begin
    in_done_d = in_done_q;
    if (out_hs_s) begin
      data_d = {8'h00, data_q[63:8]};
      keep_d = {1'b0, keep_q[7:1]};
      last_d = last_q;
      user_d = user_q;
    end else begin
      data_d = data_q;
      keep_d = keep_q;
      last_d = last_q;
      user_d = user_q;
    end
    if (pl_in_hs_s) begin
      in_done_d = s_udp_payload_axis_tlast;
      if (s_udp_payload_axis_tkeep != 8'h00) begin
        data_d = s_udp_payload_axis_tdata;
        keep_d = s_udp_payload_axis_tkeep;
        last_d = s_udp_payload_axis_tlast;
        user_d = s_udp_payload_axis_tuser;
      end else if (s_udp_payload_axis_tlast) begin
        data_d = 64'h0000_0000_0000_0000;
        keep_d = 8'h01;
        last_d = 1'b1;
        user_d = s_udp_payload_axis_tuser;
      end else begin
        in_done_d = 1'b0;
      end
    end else if (frame_end_s) begin
      in_done_d = 1'b0;
      last_d    = 1'b0;
      user_d    = 1'b0;
    end else begin
      in_done_d = in_done_q;
    end
  end

  // State, header and holding-register flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hdr_ready_q <= 1'b0;
      src_ip_q    <= 32'h0000_0000;
      dst_ip_q    <= 32'h0000_0000;
      src_port_q  <= 16'h0000;
      dst_port_q  <= 16'h0000;
      length_q    <= 16'h0000;
      ttl_q       <= 8'h00;
      data_q      <= 64'h0000_0000_0000_0000;
      keep_q      <= 8'h00;
      last_q      <= 1'b0;
      user_q      <= 1'b0;
      in_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_ready_q <= hdr_ready_d;
      src_ip_q    <= src_ip_d;
      dst_ip_q    <= dst_ip_d;
      src_port_q  <= src_port_d;
      dst_port_q  <= dst_port_d;
      length_q    <= length_d;
      ttl_q       <= ttl_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      user_q      <= user_d;
      in_done_q   <= in_done_d;
    end
  end

`ifdef UDP_ECHO_DROP_CNT_EN
  logic [15:0] drop_count_q, drop_count_d;

  // Saturating count of datagrams discarded for a foreign destination port
  always_comb begin
    if (drop_end_s && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
    else                                          drop_count_d = drop_count_q;
  end

  // Drop counter flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_count_q <= 16'h0000;
    else      drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

  assign s_udp_hdr_ready           = hdr_ready_q;
  assign s_udp_payload_axis_tready = s_ready_s;
  assign m_udp_hdr_valid           = (state_q == ST_HDR);
  assign m_udp_ip_dscp             = 6'd0;
  assign m_udp_ip_ecn              = 2'd0;
  assign m_udp_ip_ttl              = ttl_q;
  assign m_udp_ip_source_ip        = src_ip_q;
  assign m_udp_ip_dest_ip          = dst_ip_q;
  assign m_udp_source_port         = src_port_q;
  assign m_udp_dest_port           = dst_port_q;
  assign m_udp_length              = length_q;
  assign m_udp_checksum            = 16'h0000;
  assign m_udp_payload_axis_tdata  = data_q[7:0];
  assign m_udp_payload_axis_tkeep  = 8'h01;
  assign m_udp_payload_axis_tvalid = out_valid_s;
  assign m_udp_payload_axis_tlast  = out_valid_s && final_byte_s && last_q;
  assign m_udp_payload_axis_tuser  = out_valid_s && final_byte_s && last_q && user_q;

endmodule

// File: tb/tb_udp_echo_responder.sv
// Directed self-checking bench for udp_echo_responder: echo, short beat, drop,
// backpressure, empty beats and mid-frame reset.
module tb_udp_echo_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_udp_hdr_valid, s_udp_hdr_ready;
  logic [31:0] s_udp_ip_source_ip, s_udp_ip_dest_ip;
  logic [15:0] s_udp_source_port, s_udp_dest_port, s_udp_length;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic        m_udp_hdr_valid, m_udp_hdr_ready;
  logic [5:0]  m_dscp;
  logic [1:0]  m_ecn;
  logic [7:0]  m_ttl;
  logic [31:0] m_src_ip, m_dst_ip;
  logic [15:0] m_src_port, m_dst_port, m_length, m_checksum;
  logic [7:0]  m_tdata, m_tkeep;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
`ifdef UDP_ECHO_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int errors = 0;
  int checks = 0;

  // Frame description used by the streaming task
  logic [63:0] bd [4];
  logic [7:0]  bk [4];
  logic        bl [4];
  int          nbeats;
  logic [7:0]  eb [32];
  int          exp_n;
  logic        exp_user;

  udp_echo_responder dut (
    .clk(clk), .rst(rst),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_udp_ip_source_ip(s_udp_ip_source_ip), .s_udp_ip_dest_ip(s_udp_ip_dest_ip),
    .s_udp_source_port(s_udp_source_port), .s_udp_dest_port(s_udp_dest_port),
    .s_udp_length(s_udp_length),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tkeep(s_tkeep),
    .s_udp_payload_axis_tvalid(s_tvalid), .s_udp_payload_axis_tready(s_tready),
    .s_udp_payload_axis_tlast(s_tlast), .s_udp_payload_axis_tuser(s_tuser),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_udp_ip_dscp(m_dscp), .m_udp_ip_ecn(m_ecn), .m_udp_ip_ttl(m_ttl),
    .m_udp_ip_source_ip(m_src_ip), .m_udp_ip_dest_ip(m_dst_ip),
    .m_udp_source_port(m_src_port), .m_udp_dest_port(m_dst_port),
    .m_udp_length(m_length), .m_udp_checksum(m_checksum),
    .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tkeep(m_tkeep),
    .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tready(m_tready),
    .m_udp_payload_axis_tlast(m_tlast), .m_udp_payload_axis_tuser(m_tuser)
`ifdef UDP_ECHO_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hdr_ready"}, s_udp_hdr_ready, 1'b0);
    chk({tag, "_s_tready"}, s_tready, 1'b0);
    chk({tag, "_hdr_valid"}, m_udp_hdr_valid, 1'b0);
    chk({tag, "_m_tvalid"}, m_tvalid, 1'b0);
    chk({tag, "_m_tdata"}, m_tdata, 8'h00);
    chk({tag, "_m_tlast"}, m_tlast, 1'b0);
    chk({tag, "_m_tuser"}, m_tuser, 1'b0);
    chk({tag, "_hdr_fields"}, {m_src_ip, m_dst_ip}, 64'h0);
    chk({tag, "_hdr_ports"}, {m_src_port, m_dst_port, m_length, m_ttl}, 64'h0);
`ifdef UDP_ECHO_DROP_CNT_EN
    chk({tag, "_drop_count"}, drop_count, 16'h0000);
`endif
  endtask

  task automatic send_hdr(input logic [31:0] sip, input logic [31:0] dip,
                          input logic [15:0] sp, input logic [15:0] dp,
                          input logic [15:0] len, input bit echo);
    int n = 0;
    s_udp_hdr_valid = 1'b1;
    s_udp_ip_source_ip = sip; s_udp_ip_dest_ip = dip;
    s_udp_source_port = sp; s_udp_dest_port = dp; s_udp_length = len;
    #1;
    while (!s_udp_hdr_ready && n < 20) begin
      tick(); #1; n++;
    end
    chk("hdr_ready_idle", s_udp_hdr_ready, 1'b1);
    chk("idle_s_tready", s_tready, 1'b0);
    tick();
    s_udp_hdr_valid = 1'b0;
    #1;
    chk("hdr_ready_after_hs", s_udp_hdr_ready, 1'b0);
    if (echo) begin
      chk("hdr_valid", m_udp_hdr_valid, 1'b1);
      chk("hdr_src_ip", m_src_ip, dip);
      chk("hdr_dst_ip", m_dst_ip, sip);
      chk("hdr_src_port", m_src_port, dp);
      chk("hdr_dst_port", m_dst_port, sp);
      chk("hdr_length", m_length, len);
      chk("hdr_ttl", m_ttl, 8'd64);
      chk("hdr_checksum", m_checksum, 16'h0000);
      chk("hdr_dscp_ecn", {m_dscp, m_ecn}, 8'h00);
      chk("hdr_s_tready", s_tready, 1'b0);
      tick();
      chk("hdr_stable", {m_udp_hdr_valid, m_src_ip, m_src_port}, {1'b1, dip, dp});
      m_udp_hdr_ready = 1'b1;
      tick();
      m_udp_hdr_ready = 1'b0;
      #1;
      chk("hdr_valid_clear", m_udp_hdr_valid, 1'b0);
    end else begin
      chk("drop_no_hdr", m_udp_hdr_valid, 1'b0);
      chk("drop_s_tready", s_tready, 1'b1);
    end
  endtask

  // Stream the beats in bd/bk/bl and check the byte sequence eb[0..exp_n-1]
  task automatic stream(input bit toggle, input bit nobubble);
    int bi = 0, ok = 0, reg_cnt = 0, cyc = 0;
    bit in_done = 1'b0, started = 1'b0, prev_stall = 1'b0, exp_rdy;
    logic [7:0] prev_data = 8'h00;
    while (ok < exp_n && cyc < 200) begin
      s_tvalid = (bi < nbeats);
      s_tdata  = (bi < nbeats) ? bd[bi] : 64'h0;
      s_tkeep  = (bi < nbeats) ? bk[bi] : 8'h00;
      s_tlast  = (bi < nbeats) ? bl[bi] : 1'b0;
      s_tuser  = (bi < nbeats) ? (bl[bi] & exp_user) : 1'b0;
      m_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (prev_stall) begin
        chk("stall_valid_hold", m_tvalid, 1'b1);
        chk("stall_data_hold", m_tdata, prev_data);
      end
      exp_rdy = !in_done && (reg_cnt == 0 || (reg_cnt == 1 && m_tready));
      chk("s_tready", s_tready, exp_rdy);
      if (nobubble && started) chk("no_bubble", m_tvalid, 1'b1);
      if (m_tvalid) started = 1'b1;
      if (m_tvalid && m_tready) begin
        chk("byte", m_tdata, eb[ok]);
        chk("tlast", m_tlast, (ok == exp_n - 1));
        if (ok == exp_n - 1) chk("tuser", m_tuser, exp_user);
        ok++;
        reg_cnt--;
      end
      if (s_tvalid && exp_rdy) begin
        reg_cnt = (bk[bi] != 8'h00) ? $countones(bk[bi]) : (bl[bi] ? 1 : 0);
        if (bl[bi]) in_done = 1'b1;
        bi++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      tick();
      cyc++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b0;
    chk("byte_count", ok, exp_n);
    #1;
    chk("frame_end_idle", {m_tvalid, s_udp_hdr_ready}, 2'b01);
  endtask

  task automatic drop_frame(input int nb);
    for (int i = 0; i < nb; i++) begin
      s_tvalid = 1'b1; s_tdata = 64'hA5A5_0000_0000_0000 + 64'(i);
      s_tkeep = 8'hFF; s_tlast = (i == nb - 1);
      #1;
      chk("drop_beat_tready", s_tready, 1'b1);
      chk("drop_no_out", {m_tvalid, m_udp_hdr_valid}, 2'b00);
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
    chk("drop_back_idle", {s_udp_hdr_ready, s_tready}, 2'b10);
  endtask

  initial begin
    rst = 1'b0;
    s_udp_hdr_valid = 1'b0; s_udp_ip_source_ip = 32'h0; s_udp_ip_dest_ip = 32'h0;
    s_udp_source_port = 16'h0; s_udp_dest_port = 16'h0; s_udp_length = 16'h0;
    s_tdata = 64'h0; s_tkeep = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_udp_hdr_ready = 1'b0; m_tready = 1'b0;
    tick(); tick(); #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Full 8-byte beat echoed with swapped header
    send_hdr(32'h0A00_0001, 32'h0A00_0002, 16'd5000, 16'd1234, 16'd16, 1'b1);
    nbeats = 1; bd[0] = 64'h0807_0605_0403_0201; bk[0] = 8'hFF; bl[0] = 1'b1;
    exp_n = 8; exp_user = 1'b0;
    for (int i = 0; i < 8; i++) eb[i] = 8'(i + 1);
    stream(1'b0, 1'b1);

    // Three-byte last beat, tuser carried to the final byte
    send_hdr(32'h0A00_0001, 32'h0A00_0002, 16'd5001, 16'd1234, 16'd11, 1'b1);
    nbeats = 1; bd[0] = 64'h1122_3344_55CC_BBAA; bk[0] = 8'h07; bl[0] = 1'b1;
    exp_n = 3; exp_user = 1'b1;
    eb[0] = 8'hAA; eb[1] = 8'hBB; eb[2] = 8'hCC;
    stream(1'b0, 1'b1);

    // Foreign port is swallowed and counted
`ifdef UDP_ECHO_DROP_CNT_EN
    chk("drop_count_before", drop_count, 16'h0000);
`endif
    send_hdr(32'h0A00_0001, 32'h0A00_0002, 16'd5000, 16'd80, 16'd24, 1'b0);
    drop_frame(2);
`ifdef UDP_ECHO_DROP_CNT_EN
    chk("drop_count_one", drop_count, 16'h0001);
    force dut.drop_count_q = 16'hFFFF;
    tick();
    release dut.drop_count_q;
    send_hdr(32'h0A00_0003, 32'h0A00_0002, 16'd6000, 16'd81, 16'd16, 1'b0);
    drop_frame(1);
    chk("drop_count_saturated", drop_count, 16'hFFFF);
`endif

    // 16 bytes over two beats with toggling downstream ready
    send_hdr(32'h0A00_0001, 32'h0A00_0002, 16'd5002, 16'd1234, 16'd24, 1'b1);
    nbeats = 2; bk[0] = 8'hFF; bk[1] = 8'hFF; bl[0] = 1'b0; bl[1] = 1'b1;
    exp_n = 16; exp_user = 1'b0;
    for (int i = 0; i < 16; i++) eb[i] = 8'(8'h11 + i);
    bd[0] = 64'h1817_1615_1413_1211; bd[1] = 64'h201F_1E1D_1C1B_1A19;
    stream(1'b1, 1'b0);

    // Same two beats back-to-back at full rate
    send_hdr(32'h0A00_0001, 32'h0A00_0002, 16'd5003, 16'd1234, 16'd24, 1'b1);
    stream(1'b0, 1'b1);

    // Empty beats: no-last empty beat is silent, last empty beat emits 00 with tlast
    send_hdr(32'h0A00_0001, 32'h0A00_0002, 16'd5004, 16'd1234, 16'd10, 1'b1);
    nbeats = 3;
    bd[0] = 64'hFFFF_FFFF_FFFF_FFFF; bk[0] = 8'h00; bl[0] = 1'b0;
    bd[1] = 64'h0000_0000_0000_5B5A; bk[1] = 8'h03; bl[1] = 1'b0;
    bd[2] = 64'h0000_0000_0000_DEAD; bk[2] = 8'h00; bl[2] = 1'b1;
    exp_n = 3; exp_user = 1'b1;
    eb[0] = 8'h5A; eb[1] = 8'h5B; eb[2] = 8'h00;
    stream(1'b0, 1'b0);

    // Reset after three of eight bytes have left
    send_hdr(32'h0A00_0001, 32'h0A00_0002, 16'd5005, 16'd1234, 16'd16, 1'b1);
    s_tvalid = 1'b1; s_tdata = 64'h0807_0605_0403_0201; s_tkeep = 8'hFF; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pre_reset_byte", m_tdata, 8'(i + 1));
      tick();
    end
    rst = 1'b0;
    #1;
    chk_reset_outputs("midframe_reset");
    tick();
    rst = 1'b1;
    m_tready = 1'b0;
    tick();
    send_hdr(32'hC0A8_0005, 32'hC0A8_0001, 16'd7777, 16'd1234, 16'd12, 1'b1);
    nbeats = 1; bd[0] = 64'h0000_0000_4433_2211; bk[0] = 8'h0F; bl[0] = 1'b1;
    exp_n = 4; exp_user = 1'b0;
    eb[0] = 8'h11; eb[1] = 8'h22; eb[2] = 8'h33; eb[3] = 8'h44;
    stream(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_echo_responder.md
UDP_ECHO_RESPONDER -- requirements
Module: udp_echo_responder

Interface
REQ-001 The block SHALL have parameter LOCAL_PORT, default 16'd1234, the UDP destination port that is echoed.
REQ-002 The block SHALL have parameter ECHO_TTL, default 8'd64, the IP TTL of echoed datagrams.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-005 The block SHALL have inputs s_udp_hdr_valid (1), s_udp_ip_source_ip (32), s_udp_ip_dest_ip (32), s_udp_source_port (16), s_udp_dest_port (16) and s_udp_length (16), carrying the received header from the stack output side.
REQ-006 The block SHALL have output s_udp_hdr_ready  1  header accept.
REQ-007 The block SHALL have inputs s_udp_payload_axis_tdata (64), tkeep (8), tvalid (1), tlast (1) and tuser (1), carrying the received payload.
REQ-008 The block SHALL have output s_udp_payload_axis_tready  1  payload accept.
REQ-009 The block SHALL have outputs m_udp_hdr_valid (1), m_udp_ip_dscp (6), m_udp_ip_ecn (2), m_udp_ip_ttl (8), m_udp_ip_source_ip (32), m_udp_ip_dest_ip (32), m_udp_source_port (16), m_udp_dest_port (16), m_udp_length (16) and m_udp_checksum (16), carrying the reply header to the stack input side.
REQ-010 The block SHALL have input m_udp_hdr_ready  1  header accept from the stack.
REQ-011 The block SHALL have outputs m_udp_payload_axis_tdata (8), tkeep (8, constant 8'h01), tvalid (1), tlast (1) and tuser (1), carrying the reply payload.
REQ-012 The block SHALL have input m_udp_payload_axis_tready  1  payload accept.
REQ-013 The block SHALL have output drop_count  16  count of discarded datagrams, present only under UDP_ECHO_DROP_CNT_EN.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, DROP, HDR and PAYLOAD.
REQ-015 In IDLE, s_udp_hdr_ready SHALL be 1 and all other readies and valids SHALL be 0.
REQ-016 On a header handshake in IDLE, the FSM SHALL go to HDR if s_udp_dest_port == LOCAL_PORT, else to DROP.
REQ-017 On entry to HDR, the block SHALL register the swapped header: source_ip := dest_ip, dest_ip := source_ip, source_port := dest_port, dest_port := source_port.
REQ-018 The registered header SHALL also carry length copied, checksum 16'h0000, dscp 0, ecn 0 and ttl ECHO_TTL, all held stable while m_udp_hdr_valid = 1.
REQ-019 In HDR, m_udp_hdr_valid SHALL be 1, and the FSM SHALL go to PAYLOAD on the m_udp_hdr_ready handshake.
REQ-020 In DROP, s_udp_payload_axis_tready SHALL be 1, every beat SHALL be discarded, and on the tlast beat the FSM SHALL return to IDLE and drop_count SHALL increment, saturating at 16'hFFFF.
REQ-021 In PAYLOAD, the block SHALL use a one-beat 64-bit holding register, and s_udp_payload_axis_tready SHALL be 1 only when the register is empty or its final byte handshakes in the same cycle.
REQ-022 Bytes SHALL be emitted lane 0 first (tdata[7:0]), only for lanes with tkeep set; tkeep is contiguous from lane 0.
REQ-023 The first output byte SHALL be valid in the cycle after its beat is accepted.
REQ-024 With m_udp_payload_axis_tready held at 1, throughput SHALL be 1 byte per cycle, with no bubble between beats.
REQ-025 m_udp_payload_axis_tlast SHALL assert only on the last kept byte of the input tlast beat, with tuser copied from that beat.
REQ-026 After the tlast byte handshake, the FSM SHALL go to IDLE; a new header MAY be accepted in the following cycle.
REQ-027 An accepted beat with tkeep == 0 and tlast == 0 SHALL produce no output.
REQ-028 An accepted beat with tkeep == 0 and tlast == 1 SHALL emit one byte 8'h00 with tlast = 1.
REQ-029 m_udp_payload_axis_tvalid and tdata SHALL remain stable while tready = 0.

Reset
REQ-030 While rst = 0, the FSM SHALL be in IDLE and the holding register SHALL be empty.
REQ-031 While rst = 0, all valid, ready, tlast and tuser outputs and all header and data outputs SHALL be 0; drop_count SHALL be 0.
REQ-032 A reset mid-frame SHALL discard the partial frame, and the block SHALL process the next header normally after rst returns to 1.

Configuration
REQ-033 With UDP_ECHO_DROP_CNT_EN defined, drop_count SHALL exist and count per REQ-020.
REQ-034 Without UDP_ECHO_DROP_CNT_EN, the drop_count port and counter SHALL be absent, and DROP behaviour SHALL be otherwise identical.

Verification
REQ-035 The bench SHALL send a header with src 0x0A000001:5000, dst 0x0A000002:1234, length 16, then one beat 0x0807060504030201 with tkeep FF and tlast -> required: reply header src 0x0A000002:1234, dst 0x0A000001:5000, ttl 64, checksum 0; bytes 01..08; tlast on 08.
REQ-036 The bench SHALL send a 3-byte beat 0x..CCBBAA with tkeep 07 and tlast -> required: AA, BB, CC out, tlast on CC only.
REQ-037 The bench SHALL send dest_port 80 with two beats -> required: no reply output; both beats consumed; drop_count 0 -> 1. A further case SHALL preload drop_count to 0xFFFF -> required: it stays 0xFFFF.
REQ-038 The bench SHALL drive 16 bytes over two beats with m_udp_payload_axis_tready toggling 1/0 -> required: 16 bytes in order with none lost or duplicated; s_tready low while the holding register is non-empty.
REQ-039 The bench SHALL assert rst after 3 of 8 bytes are output -> required: all outputs 0 immediately; the next valid datagram is echoed exactly.
